logic_operand_loader: RTL

LOGIC_OPERAND_LOADER -- requirements
Module: logic_operand_loader

---
 rtl/logic_pkg.sv | 16 +
 rtl/btn_debounce.sv | 53 +++++
 rtl/logic_operand_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared types and constants for the operand loader and the logic unit it feeds.
package logic_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    LOAD_F = 2'b10,
    READY  = 2'b11
  } load_state_t;

  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_XOR = 2'b10;
  localparam logic [1:0] FN_NOR = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer, debounce counter and single-cycle press pulse.
// A clean rise stable from cycle 0 yields the press pulse in cycle 2+DEBOUNCE_CYCLES (offset 0).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= {CW{1'b0}};
      press_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= sync2_r;
      press_r <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      press_r <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/logic_operand_loader.sv
// Loads operands A, B and function F from the switches, one debounced press at a time.
module logic_operand_loader
  import logic_pkg::*;
#(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] SW,
  input  logic           BTN,
  output logic [2*N-1:0] A,
  output logic [2*N-1:0] B,
  output logic [1:0]     F,
  output logic           VALID,
  output logic [1:0]     STATE
);

  localparam int W = 2 * N;

  logic [W-1:0] sw_sync1_r;
  logic [W-1:0] sw_sync2_r;
  logic         press_s;

  load_state_t  state_r, state_nxt_s;
  logic [W-1:0] a_r, a_nxt_s;
  logic [W-1:0] b_r, b_nxt_s;
  logic [1:0]   f_r, f_nxt_s;
  logic         valid_r, valid_nxt_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (BTN),
    .press (press_s)
  );

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_r <= {W{1'b0}};
      sw_sync2_r <= {W{1'b0}};
    end else begin
      sw_sync1_r <= SW;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  // Next-state and next-operand decode; everything holds unless a press arrives.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    f_nxt_s     = f_r;
    valid_nxt_s = valid_r;
    if (press_s) begin
      case (state_r)
        LOAD_A: begin
          a_nxt_s     = sw_sync2_r;
          state_nxt_s = LOAD_B;
        end
        LOAD_B: begin
          b_nxt_s     = sw_sync2_r;
          state_nxt_s = LOAD_F;
        end
        LOAD_F: begin
          f_nxt_s     = sw_sync2_r[1:0];
          valid_nxt_s = 1'b1;
          state_nxt_s = READY;
        end
        READY: begin
          valid_nxt_s = 1'b0;
          state_nxt_s = LOAD_A;
        end
        default: begin
          valid_nxt_s = 1'b0;
          state_nxt_s = LOAD_A;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD_A;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      f_r     <= 2'b00;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      f_r     <= f_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign A     = a_r;
  assign B     = b_r;
  assign F     = f_r;
  assign VALID = valid_r;
  assign STATE = state_r;

endmodule
